// File: rtl/pipe_pkg.sv
// Shared control-bundle types for the inter-stage pipeline registers.
// The bubble value encodes a harmless no-op control word.
package pipe_pkg;

    localparam int CTRL_W = 11;

    typedef struct packed {
        logic       rd_wren;
        logic       lsu_wren;
        logic       lsu_rden;
        logic       jal;
        logic       branch;
        logic       opb_sel;
        logic       alu_dec;
        logic [1:0] opa_sel;
        logic [1:0] wb_sel;
    } ctrl_bundle_t;

    localparam ctrl_bundle_t CTRL_BUBBLE = '0;

    function automatic logic [1:0] occ_of(input logic a, input logic b);
        return {a & b, a ^ b};
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter with synchronous active-low clear.
// Holds at all-ones once reached.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         i_clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge i_clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (inc && !(&cnt)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/pipe_stage_ctrl.sv
// Control-bundle pipeline register with valid/ready, stall, flush,
// optional skid entry and saturating stall/flush event counters.
module pipe_stage_ctrl
    import pipe_pkg::*;
#(
    parameter int               WIDTH      = CTRL_W,
    parameter logic [WIDTH-1:0] BUBBLE_VAL = WIDTH'(CTRL_BUBBLE),
    parameter int               SKID       = 1,
    parameter int               CNT_W      = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_flush,
    input  logic             i_stall,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_data,
    output logic [1:0]       o_occ,
    output logic [CNT_W-1:0] o_stall_cnt,
    output logic [CNT_W-1:0] o_flush_cnt
);

    logic             m_valid, m_valid_d;
    logic [WIDTH-1:0] m_data, m_data_d;
    logic             s_valid, s_valid_d;
    logic [WIDTH-1:0] s_data, s_data_d;
    logic             rdy_q;
    logic             drain;
    logic             acc;
    logic             stall_ev;
    logic             flush_ev;

    assign drain = m_valid & i_ready & ~i_stall;
    assign acc   = i_valid & o_ready;

    // Skid build registers ready so the upstream path sees a flop.
    assign o_ready = (SKID != 0) ? rdy_q
                   : (~m_valid | (i_ready & ~i_stall));

    assign o_valid = m_valid;
    assign o_data  = m_valid ? m_data : BUBBLE_VAL;
    assign o_occ   = occ_of(m_valid, s_valid);

    always_comb begin
        m_valid_d = m_valid;
        m_data_d  = m_data;
        s_valid_d = s_valid;
        s_data_d  = s_data;
        if (i_flush) begin
            m_valid_d = 1'b0;
            m_data_d  = BUBBLE_VAL;
            s_valid_d = 1'b0;
            s_data_d  = BUBBLE_VAL;
        end else if (SKID == 0) begin
            if (acc) begin
                m_valid_d = 1'b1;
                m_data_d  = i_data;
            end else if (drain) begin
                m_valid_d = 1'b0;
                m_data_d  = BUBBLE_VAL;
            end
        end else if (!m_valid || drain) begin
            // S is older than anything upstream, so it refills M first.
            if (s_valid) begin
                m_valid_d = 1'b1;
                m_data_d  = s_data;
                s_valid_d = 1'b0;
                s_data_d  = BUBBLE_VAL;
            end else if (acc) begin
                m_valid_d = 1'b1;
                m_data_d  = i_data;
            end else begin
                m_valid_d = 1'b0;
                m_data_d  = BUBBLE_VAL;
            end
        end else if (acc) begin
            s_valid_d = 1'b1;
            s_data_d  = i_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            m_valid <= 1'b0;
            m_data  <= BUBBLE_VAL;
            s_valid <= 1'b0;
            s_data  <= BUBBLE_VAL;
            rdy_q   <= 1'b1;
        end else begin
            m_valid <= m_valid_d;
            m_data  <= m_data_d;
            s_valid <= s_valid_d;
            s_data  <= s_data_d;
            rdy_q   <= ~s_valid_d;
        end
    end

    assign stall_ev = m_valid & ~drain;
    assign flush_ev = i_flush & (m_valid | s_valid);

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .i_clk (i_clk),
        .rst_n (i_rst_n),
        .inc   (stall_ev),
        .cnt   (o_stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .i_clk (i_clk),
        .rst_n (i_rst_n),
        .inc   (flush_ev),
        .cnt   (o_flush_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_ctrl.sv
// Bench for pipe_stage_ctrl: skid build (CNT_W=4) and plain build side
// by side, both compared against a FIFO-level reference model.
module tb_pipe_stage_ctrl;

    logic        i_clk;
    logic        rst_n;
    logic        flush;
    logic        stall;
    logic        valid;
    logic        ready;
    logic [10:0] data;

    logic        rdy1, ov1;
    logic [10:0] od1;
    logic [1:0]  oc1;
    logic [3:0]  sc1, fc1;

    logic        rdy0, ov0;
    logic [10:0] od0;
    logic [1:0]  oc0;
    logic [15:0] sc0, fc0;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 0;

    // Model: per build, a FIFO of held bundles (front = output) + counters.
    logic [10:0] ment [2][2];
    int          mn   [2];
    int          msc  [2];
    int          mfc  [2];

    pipe_stage_ctrl #(.WIDTH(11), .SKID(1), .CNT_W(4)) dut1 (
        .i_clk       (i_clk),
        .i_rst_n     (rst_n),
        .i_flush     (flush),
        .i_stall     (stall),
        .i_valid     (valid),
        .o_ready     (rdy1),
        .i_data      (data),
        .o_valid     (ov1),
        .i_ready     (ready),
        .o_data      (od1),
        .o_occ       (oc1),
        .o_stall_cnt (sc1),
        .o_flush_cnt (fc1)
    );

    pipe_stage_ctrl #(.WIDTH(11), .SKID(0), .CNT_W(16)) dut0 (
        .i_clk       (i_clk),
        .i_rst_n     (rst_n),
        .i_flush     (flush),
        .i_stall     (stall),
        .i_valid     (valid),
        .o_ready     (rdy0),
        .i_data      (data),
        .o_valid     (ov0),
        .i_ready     (ready),
        .o_data      (od0),
        .o_occ       (oc0),
        .o_stall_cnt (sc0),
        .o_flush_cnt (fc0)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic expect_eq(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit m_ready(input int d);
        if (d == 1) return mn[1] < 2;
        return (mn[0] == 0) || (ready && !stall);
    endfunction

    task automatic check_dut(input int d, input logic ov,
                             input logic [10:0] od, input logic [1:0] oc,
                             input logic ordy, input logic [15:0] osc,
                             input logic [15:0] ofc);
        bit v;
        v = mn[d] > 0;
        expect_eq($sformatf("d%0d_valid", d), 32'(ov), 32'(v));
        expect_eq($sformatf("d%0d_data", d), 32'(od),
                  v ? 32'(ment[d][0]) : 32'd0);
        expect_eq($sformatf("d%0d_occ", d), 32'(oc), 32'(mn[d]));
        expect_eq($sformatf("d%0d_ready", d), 32'(ordy), 32'(m_ready(d)));
        expect_eq($sformatf("d%0d_stall_cnt", d), 32'(osc), 32'(msc[d]));
        expect_eq($sformatf("d%0d_flush_cnt", d), 32'(ofc), 32'(mfc[d]));
    endtask

    task automatic model_step(input int d);
        bit v, dr, ac;
        int sat;
        v   = mn[d] > 0;
        dr  = v && ready && !stall;
        ac  = valid && m_ready(d);
        sat = (d == 1) ? 15 : 65535;
        if (!rst_n) begin
            mn[d]  = 0;
            msc[d] = 0;
            mfc[d] = 0;
        end else begin
            if (v && !dr && msc[d] < sat) msc[d]++;
            if (flush && v && mfc[d] < sat) mfc[d]++;
            if (flush) begin
                mn[d] = 0;
            end else begin
                if (dr) begin
                    ment[d][0] = ment[d][1];
                    mn[d]--;
                end
                if (ac) begin
                    ment[d][mn[d]] = data;
                    mn[d]++;
                end
            end
        end
    endtask

    task automatic drive(input logic r, input logic f, input logic s,
                         input logic v, input logic [10:0] dt,
                         input logic rd);
        @(negedge i_clk);
        rst_n = r;
        flush = f;
        stall = s;
        valid = v;
        data  = dt;
        ready = rd;
        #1;
        if (chk_en) begin
            check_dut(1, ov1, od1, oc1, rdy1, 16'(sc1), 16'(fc1));
            check_dut(0, ov0, od0, oc0, rdy0, sc0, fc0);
        end
        model_step(1);
        model_step(0);
        @(posedge i_clk);
        #1;
        chk_en = 1;
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            mn[d] = 0;
            msc[d] = 0;
            mfc[d] = 0;
        end
        rst_n = 0; flush = 0; stall = 0; valid = 0; ready = 0; data = '0;

        drive(0, 0, 0, 1, 11'h7FF, 1);
        drive(0, 0, 0, 1, 11'h7FF, 1);
        expect_eq("rst_valid", 32'(ov1), 0);
        expect_eq("rst_data", 32'(od1), 0);
        expect_eq("rst_occ", 32'(oc1), 0);
        expect_eq("rst_stall_cnt", 32'(sc1), 0);
        expect_eq("rst_flush_cnt", 32'(fc1), 0);
        expect_eq("rst_ready", 32'(rdy1), 1);

        for (int i = 1; i <= 16; i++) drive(1, 0, 0, 1, 11'(i), 1);
        drive(1, 0, 0, 0, '0, 1);
        expect_eq("stream_stall_cnt", 32'(sc1), 0);
        expect_eq("stream_occ", 32'(oc1), 0);

        drive(1, 0, 0, 1, 11'h155, 1);
        drive(1, 0, 0, 1, 11'h2AA, 0);
        drive(1, 0, 0, 1, 11'h3FF, 0);
        expect_eq("bp_occ", 32'(oc1), 2);
        expect_eq("bp_ready", 32'(rdy1), 0);
        expect_eq("bp_head", 32'(od1), 32'h155);
        drive(1, 0, 0, 1, 11'h3FF, 1);
        expect_eq("bp_second", 32'(od1), 32'h2AA);
        drive(1, 0, 0, 1, 11'h3FF, 1);
        expect_eq("bp_third", 32'(od1), 32'h3FF);
        expect_eq("bp_third_occ", 32'(oc1), 1);
        drive(1, 0, 0, 0, '0, 1);

        drive(1, 0, 0, 1, 11'h155, 1);
        drive(1, 0, 0, 1, 11'h2AA, 0);
        expect_eq("fl_pre_occ", 32'(oc1), 2);
        drive(1, 1, 0, 1, 11'h0F0, 0);
        expect_eq("fl_valid", 32'(ov1), 0);
        expect_eq("fl_data", 32'(od1), 0);
        expect_eq("fl_occ", 32'(oc1), 0);
        expect_eq("fl_cnt", 32'(fc1), 1);
        drive(1, 1, 0, 0, '0, 1);
        expect_eq("fl_empty_cnt", 32'(fc1), 1);

        drive(1, 0, 0, 1, 11'h123, 1);
        for (int i = 0; i < 20; i++) begin
            drive(1, 0, 1, 0, '0, 1);
            expect_eq("stall_hold", 32'(od1), 32'h123);
        end
        expect_eq("stall_sat", 32'(sc1), 15);
        drive(1, 0, 0, 0, '0, 1);

        for (int k = 0; k < 12; k++) drive(1, 0, 0, 1, 11'(k + 11'h40), 1'(k % 2 == 0));
        for (int k = 0; k < 3; k++) drive(1, 0, 0, 0, '0, 1);
        expect_eq("tog_occ0", 32'(oc0), 0);

        for (int i = 0; i < 3000; i++) begin
            drive(1'($urandom_range(63) != 0),
                  1'($urandom_range(15) == 0),
                  1'($urandom_range(3) == 0),
                  1'($urandom_range(3) != 0),
                  11'($urandom),
                  1'($urandom_range(2) != 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
